jk_universal_reg: RTL

JK_UNIVERSAL_REG -- requirements
Module: jk_universal_reg

---
 rtl/jk_reg_pkg.sv | 26 ++
 rtl/jk_cell.sv | 32 +++
 rtl/jk_universal_reg.sv | 110 +++++++++++
 3 files changed

// File: rtl/jk_reg_pkg.sv
// Purpose: mode encoding and mode type shared by the JK universal register slice.
// Latency: n/a (type/constant definitions only).
// Backpressure: n/a.
package jk_reg_pkg;

  localparam logic [2:0] MODE_HOLD   = 3'b000;
  localparam logic [2:0] MODE_JK     = 3'b001;
  localparam logic [2:0] MODE_LOAD   = 3'b010;
  localparam logic [2:0] MODE_SHL    = 3'b011;
  localparam logic [2:0] MODE_SHR    = 3'b100;
  localparam logic [2:0] MODE_CNT_UP = 3'b101;
  localparam logic [2:0] MODE_CNT_DN = 3'b110;
  localparam logic [2:0] MODE_CLR    = 3'b111;

  typedef enum logic [2:0] {
    HOLD   = MODE_HOLD,
    JK     = MODE_JK,
    LOAD   = MODE_LOAD,
    SHL    = MODE_SHL,
    SHR    = MODE_SHR,
    CNT_UP = MODE_CNT_UP,
    CNT_DN = MODE_CNT_DN,
    CLR    = MODE_CLR
  } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// Purpose: single-bit JK flip-flop (00 hold, 01 clear, 10 set, 11 toggle).
// Latency: 1 clk from j/k to q; reset acts immediately.
// Backpressure: none, updates every rising edge.
// Ports: clk, reset (async, active-high), j, k in; q, qbar (= ~q at all times) out.
module jk_cell #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  // Derived from q rather than stored, so it can never disagree with q.
  assign qbar = ~q;

endmodule

// File: rtl/jk_universal_reg.sv
// Purpose: WIDTH-bit universal register (hold/JK/load/shift/count/clear) built from JK cells.
// Latency: 1 clk from mode/data to q; tc is combinational from mode and q.
// Backpressure: none, an operation is applied on every rising edge.
// Ports: clk, reset (async, active-high), mode[2:0], j, k, load_data, serial_in in;
//        q, qbar, tc out. Macro JK_UNIVERSAL_REG_COUNT_EN enables CNT_UP/CNT_DN and tc;
//        without it those modes hold and tc is tied low.
module jk_universal_reg
  import jk_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc
);

  jk_mode_t         mode_e;
  logic [WIDTH-1:0] cell_j;
  logic [WIDTH-1:0] cell_k;
  logic [WIDTH-1:0] shl_nxt;
  logic [WIDTH-1:0] shr_nxt;

  assign mode_e  = jk_mode_t'(mode);
  assign shl_nxt = {q[WIDTH-2:0], serial_in};
  assign shr_nxt = {serial_in, q[WIDTH-1:1]};

`ifdef JK_UNIVERSAL_REG_COUNT_EN
  // Ripple toggle enables: bit i flips when every lower bit is 1 (up) or 0 (down).
  logic [WIDTH-1:0] up_tog;
  logic [WIDTH-1:0] dn_tog;

  always_comb begin
    up_tog    = '0;
    dn_tog    = '0;
    up_tog[0] = 1'b1;
    dn_tog[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      up_tog[i] = up_tog[i-1] & q[i-1];
      dn_tog[i] = dn_tog[i-1] & ~q[i-1];
    end
  end

  assign tc = ((mode_e == CNT_UP) && (&q)) || ((mode_e == CNT_DN) && ~(|q));
`else
  assign tc = 1'b0;
`endif

  // Every mode is expressed as per-bit J/K pairs; a data value d maps to J=d, K=~d.
  always_comb begin
    cell_j = '0;
    cell_k = '0;
    case (mode_e)
      JK: begin
        cell_j = j;
        cell_k = k;
      end
      LOAD: begin
        cell_j = load_data;
        cell_k = ~load_data;
      end
      SHL: begin
        cell_j = shl_nxt;
        cell_k = ~shl_nxt;
      end
      SHR: begin
        cell_j = shr_nxt;
        cell_k = ~shr_nxt;
      end
`ifdef JK_UNIVERSAL_REG_COUNT_EN
      CNT_UP: begin
        cell_j = up_tog;
        cell_k = up_tog;
      end
      CNT_DN: begin
        cell_j = dn_tog;
        cell_k = dn_tog;
      end
`endif
      CLR: begin
        cell_k = '1;
      end
      default: begin
        cell_j = '0;
        cell_k = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell #(
      .RESET_VALUE (RESET_VALUE[i])
    ) u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (cell_j[i]),
      .k     (cell_k[i]),
      .q     (q[i]),
      .qbar  (qbar[i])
    );
  end

endmodule
